forward_scoreboard: RTL and testbench
=====================================

Name: forward_scoreboard

Overview:
- Parametrised successor to the two-source, two-stage forwarding unit.
- Tracks in-flight register writers in an internal shadow pipeline of DEPTH stages (default E/M/W) and produces per-source forward selects with youngest-producer priority.
- Also produces a load-use style stall when the youngest matching producer's data is not yet forwardable.
- Sits beside the ID stage: observes each instruction as it leaves D, and drives the operand-mux selects and the D-stage stall/bubble control.

Parameters:
- DEPTH, 3, number of tracked post-D stages (index 0 = E, 1 = M, 2 = W).
- NUM_SRC, 2, number of source operands checked per cycle.
- RA_W, 5, register address width.
- SEL_W, $clog2(DEPTH+1), width of one select code (derived).
- STG_W, $clog2(DEPTH) (min 1), width of ready-stage field (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- iFreeze  in  1  global pipeline freeze; tracker holds state.
- iFlush  in  1  kill the instruction leaving D (bubble into stage 0).
- iIssue_RegWrite  in  1  instruction leaving D writes a register.
- iIssue_wsel  in  RA_W  its destination register.
- iIssue_rdy_stage  in  STG_W  first tracked stage at which its result is forwardable (ALU=0, load=1).
- iSrc_sel  in  NUM_SRC*RA_W  source register numbers of the instruction in D, packed, source 0 at LSBs.
- iSrc_used  in  NUM_SRC  per-source "operand actually read" flag.
- oFU_Sel  out  NUM_SRC*SEL_W  per-source select: 0 = register file, k+1 = forward from tracked stage k.
- oStall  out  1  hold D/F; a bubble is inserted into stage 0.

Behaviour:
- State: DEPTH entries, each {valid, wsel, rdy_stage}. Entry k is in stage k.
- Reset (async, rst_n=0): all valid bits cleared immediately, without a clock edge. oFU_Sel = 0 and oStall = 0 while in reset and after.
- Capture: iIssue_rdy_stage > DEPTH-1 saturates to DEPTH-1. An iIssue_wsel of 0 is captured with valid=0.
- Per clock edge, rst_n=1:
  - iFreeze=1: all entries hold; iFlush is ignored. Control keeps iFlush asserted until the freeze drops.
  - iFreeze=0: entry[k] <= entry[k-1] for k ≥ 1.
  - Entry[0] <= bubble (valid=0) if oStall|iFlush|!iIssue_RegWrite; otherwise {1, iIssue_wsel, rdy_stage}.
  - Entry[DEPTH-1] falls off the end; the register file is write-through from that point.
- Match, combinational, per source s:
  - A source matches entry k when iSrc_used[s] & iSrc_sel[s]≠0 & valid[k] & wsel[k]==iSrc_sel[s].
  - Youngest producer wins: the lowest matching k.
  - If k ≥ rdy_stage[k], then sel[s] = k+1; otherwise sel[s] = 0 and the source requests a stall.
  - No match: sel[s] = 0.
- oStall is the OR of all per-source stall requests. It depends only on state and D-stage inputs, never on iIssue_*, so there is no combinational loop.
- An older ready entry is never used when a younger not-ready entry matches; the stall takes precedence.
- Latency: selects and stall are valid in the same cycle as iSrc_*. A producer captured at edge n is visible from the cycle after edge n.
- A stalled load-use with rdy_stage=r resolves after exactly r bubble cycles, provided there is no freeze.
- Register 0 never forwards and never stalls.

Decomposition:
- Shared package fwd_pkg holds:
  - SEL_REGFILE = 0.
  - Entry typedef fwd_entry_t {valid, wsel[RA_W], rdy_stage[STG_W]}.
  - Functions sel_width(DEPTH) and stg_width(DEPTH).
- One sub-module, fwd_src_match: a per-source priority matcher over DEPTH entries that returns {sel, stall_req}. It is instantiated NUM_SRC times through a generate loop.
- The top level holds only the entry shift register and the stall OR.

Test Plan:
- ALU back-to-back: issue wsel=5, rdy=0; next cycle iSrc_sel[0]=5, used=1 -> oFU_Sel[0]=1, oStall=0. One cycle later the same source -> sel=2, then sel=3, then sel=0.
- Load-use: issue wsel=3, rdy=1; next cycle src0=3 -> oStall=1, sel=0, bubble captured. Following cycle -> oStall=0, sel=2.
- Priority: issue wsel=7 twice consecutively (rdy=0); src1=7 -> sel[1]=1, not 2. Src0=9 at the same time -> sel[0]=0.
- r0 and unused: issue wsel=0; src0=0 -> sel 0, no stall. Issue wsel=4 with iSrc_used[1]=0, src1=4 -> sel[1]=0.
- Freeze/flush: with wsel=6 at stage 0, iFreeze=1 for 3 cycles -> sel stays 1. iFlush=1 with iFreeze=0 and issue wsel=8 -> next cycle src=8 gives sel 0.
- Async reset mid-operation: entries valid with src matching (sel=2); drop rst_n between edges -> oFU_Sel=0 and oStall=0 immediately, and they stay 0 after release until a new issue.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding scoreboard: default geometry,
// select encoding, tracker entry layout and width helpers.
package fwd_pkg;

    localparam int FWD_DEPTH   = 3;
    localparam int FWD_NUM_SRC = 2;
    localparam int FWD_RA_W    = 5;

    // Select code meaning "take the operand from the register file".
    localparam int SEL_REGFILE = 0;

    // One code per tracked stage plus the register-file code.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a stage index; never narrower than one bit.
    function automatic int stg_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    localparam int FWD_STG_W = stg_width(FWD_DEPTH);

    // Layout of one tracker entry at the default geometry.
    typedef struct packed {
        logic                 valid;
        logic [FWD_RA_W-1:0]  wsel;
        logic [FWD_STG_W-1:0] rdy_stage;
    } fwd_entry_t;

endpackage

// File: rtl/forward_scoreboard_if.sv
// Issue / source-operand / forward-select bundle between the decode stage
// and the forwarding scoreboard.
interface forward_scoreboard_if
    import fwd_pkg::*;
#(
    parameter int DEPTH   = FWD_DEPTH,
    parameter int NUM_SRC = FWD_NUM_SRC,
    parameter int RA_W    = FWD_RA_W,
    parameter int SEL_W   = sel_width(DEPTH),
    parameter int STG_W   = stg_width(DEPTH)
);

    logic                     iFreeze;
    logic                     iFlush;
    logic                     iIssue_RegWrite;
    logic [RA_W-1:0]          iIssue_wsel;
    logic [STG_W-1:0]         iIssue_rdy_stage;
    logic [NUM_SRC*RA_W-1:0]  iSrc_sel;
    logic [NUM_SRC-1:0]       iSrc_used;
    logic [NUM_SRC*SEL_W-1:0] oFU_Sel;
    logic                     oStall;

    modport master (
        output iFreeze, iFlush, iIssue_RegWrite, iIssue_wsel, iIssue_rdy_stage,
        output iSrc_sel, iSrc_used,
        input  oFU_Sel, oStall
    );

    modport slave (
        input  iFreeze, iFlush, iIssue_RegWrite, iIssue_wsel, iIssue_rdy_stage,
        input  iSrc_sel, iSrc_used,
        output oFU_Sel, oStall
    );

endinterface

// File: rtl/fwd_src_match.sv
// Priority matcher for one source operand: finds the youngest in-flight
// writer of the source register and either forwards from it or asks for a
// stall when its result is not yet available.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int DEPTH = FWD_DEPTH,
    parameter int RA_W  = FWD_RA_W,
    parameter int SEL_W = sel_width(DEPTH),
    parameter int STG_W = stg_width(DEPTH)
) (
    input  logic [RA_W-1:0]              srcSel,
    input  logic                         srcUsed,
    input  logic [DEPTH-1:0]             entValid,
    input  logic [DEPTH-1:0][RA_W-1:0]   entWsel,
    input  logic [DEPTH-1:0][STG_W-1:0]  entRdyStage,
    output logic [SEL_W-1:0]             sel,
    output logic                         stallReq
);

    logic found;

    // Scan from the youngest stage; the first hit decides forward vs. stall,
    // so an older ready copy can never mask a younger not-ready one.
    always_comb begin
        sel      = SEL_W'(SEL_REGFILE);
        stallReq = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && srcUsed && (srcSel != '0) && entValid[k] &&
                (entWsel[k] == srcSel)) begin
                found = 1'b1;
                if (STG_W'(k) >= entRdyStage[k]) begin
                    sel = SEL_W'(k + 1);
                end else begin
                    stallReq = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: shadows the post-decode pipeline with DEPTH tracker
// entries and turns per-source matches into operand-mux selects and a
// decode-stage stall.
module forward_scoreboard
    import fwd_pkg::*;
#(
    parameter int DEPTH   = FWD_DEPTH,
    parameter int NUM_SRC = FWD_NUM_SRC,
    parameter int RA_W    = FWD_RA_W,
    parameter int SEL_W   = sel_width(DEPTH),
    parameter int STG_W   = stg_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    forward_scoreboard_if.slave bus
);

    localparam logic [STG_W-1:0] LAST_STG = STG_W'(DEPTH - 1);

    logic [DEPTH-1:0]             entValid;
    logic [DEPTH-1:0][RA_W-1:0]   entWsel;
    logic [DEPTH-1:0][STG_W-1:0]  entRdyStage;

    logic [NUM_SRC-1:0]       stallReq;
    logic [NUM_SRC*SEL_W-1:0] selVec;
    logic                     stall;
    logic                     captureVld;
    logic [STG_W-1:0]         captureRdy;

    // Entry for the instruction leaving D: bubble when stalled, flushed, not
    // a writer, or writing r0; ready stage clamped to the last tracked stage.
    always_comb begin
        captureRdy = (bus.iIssue_rdy_stage > LAST_STG) ? LAST_STG : bus.iIssue_rdy_stage;
        captureVld = bus.iIssue_RegWrite & ~bus.iFlush & ~stall & (bus.iIssue_wsel != '0);
    end

    // Valid bits: cleared asynchronously, shifted one stage per unfrozen clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entValid <= '0;
        end else if (!bus.iFreeze) begin
            entValid[0] <= captureVld;
            for (int k = 1; k < DEPTH; k++) begin
                entValid[k] <= entValid[k-1];
            end
        end
    end

    // Destination / ready-stage payload: qualified by the valid bits, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        if (!bus.iFreeze) begin
            entWsel[0]     <= bus.iIssue_wsel;
            entRdyStage[0] <= captureRdy;
            for (int k = 1; k < DEPTH; k++) begin
                entWsel[k]     <= entWsel[k-1];
                entRdyStage[k] <= entRdyStage[k-1];
            end
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : gSrc
        fwd_src_match #(
            .DEPTH (DEPTH),
            .RA_W  (RA_W),
            .SEL_W (SEL_W),
            .STG_W (STG_W)
        ) uMatch (
            .srcSel      (bus.iSrc_sel[s*RA_W +: RA_W]),
            .srcUsed     (bus.iSrc_used[s]),
            .entValid    (entValid),
            .entWsel     (entWsel),
            .entRdyStage (entRdyStage),
            .sel         (selVec[s*SEL_W +: SEL_W]),
            .stallReq    (stallReq[s])
        );
    end

    assign stall       = |stallReq;
    assign bus.oStall  = stall;
    assign bus.oFU_Sel = selVec;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: each step pushes the expected
// selects/stall onto a scoreboard queue and pops them against the outputs.
module tb_forward_scoreboard;
    import fwd_pkg::*;

    localparam int DEPTH   = 3;
    localparam int NUM_SRC = 2;
    localparam int RA_W    = 5;
    localparam int SEL_W   = sel_width(DEPTH);
    localparam int STG_W   = stg_width(DEPTH);

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    forward_scoreboard_if #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .RA_W(RA_W)) bus();

    forward_scoreboard #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .RA_W(RA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string                    tag;
        logic [NUM_SRC*SEL_W-1:0] sel;
        logic                     stall;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iFreeze          = 1'b0;
        bus.iFlush           = 1'b0;
        bus.iIssue_RegWrite  = 1'b0;
        bus.iIssue_wsel      = '0;
        bus.iIssue_rdy_stage = '0;
    endtask

    task automatic issue(input int w, input int r);
        bus.iIssue_RegWrite  = 1'b1;
        bus.iIssue_wsel      = RA_W'(w);
        bus.iIssue_rdy_stage = STG_W'(r);
    endtask

    task automatic src(input int s0, input bit u0, input int s1, input bit u1);
        bus.iSrc_sel  = {RA_W'(s1), RA_W'(s0)};
        bus.iSrc_used = {u1, u0};
    endtask

    task automatic checkOut();
        exp_t e;
        e = expQ.pop_front();
        compared++;
        assert (bus.oFU_Sel === e.sel) else begin
            mismatched++;
            $error("FAIL %s oFU_Sel: observed %h expected %h", e.tag, bus.oFU_Sel, e.sel);
        end
        compared++;
        assert (bus.oStall === e.stall) else begin
            mismatched++;
            $error("FAIL %s oStall: observed %b expected %b", e.tag, bus.oStall, e.stall);
        end
    endtask

    task automatic expectOut(input string tag, input int e0, input int e1, input bit st);
        exp_t e;
        e.tag   = tag;
        e.sel   = {SEL_W'(e1), SEL_W'(e0)};
        e.stall = st;
        expQ.push_back(e);
        #1;
        checkOut();
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        src(0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        expectOut("reset", 0, 0, 0);
        #9 rst_n = 1'b1;
        tick();

        // ALU producer walks E -> M -> W -> gone
        issue(5, 0);
        tick();
        idle();
        src(5, 1, 0, 0);
        expectOut("alu_e", 1, 0, 0);
        tick();
        expectOut("alu_m", 2, 0, 0);
        tick();
        expectOut("alu_w", 3, 0, 0);
        tick();
        expectOut("alu_gone", 0, 0, 0);

        // load-use: one stall, issue during stall is dropped
        src(0, 0, 0, 0);
        issue(3, 1);
        expectOut("lu_issue", 0, 0, 0);
        tick();
        idle();
        issue(10, 0);
        src(3, 1, 0, 0);
        expectOut("lu_stall", 0, 0, 1);
        tick();
        idle();
        src(3, 1, 10, 1);
        expectOut("lu_resolve", 2, 0, 0);
        src(0, 0, 0, 0);
        tick(); tick(); tick();

        // youngest-producer priority
        issue(7, 0);
        tick();
        issue(7, 0);
        tick();
        idle();
        src(9, 1, 7, 1);
        expectOut("prio", 0, 1, 0);
        // younger not-ready copy beats older ready copies
        issue(7, 1);
        tick();
        idle();
        src(0, 0, 7, 1);
        expectOut("stall_prec", 0, 0, 1);
        tick();
        expectOut("prec_resolve", 0, 2, 0);
        src(0, 0, 0, 0);
        tick(); tick(); tick();

        // ready stage 3 saturates to 2: two stall cycles, then forward from W
        issue(11, 3);
        tick();
        idle();
        src(11, 1, 0, 0);
        expectOut("sat_e", 0, 0, 1);
        tick();
        expectOut("sat_m", 0, 0, 1);
        tick();
        expectOut("sat_w", 3, 0, 0);
        src(0, 0, 0, 0);
        tick();

        // r0 never tracked; unused source never forwards
        issue(0, 0);
        tick();
        idle();
        src(0, 1, 0, 1);
        expectOut("r0", 0, 0, 0);
        issue(4, 0);
        tick();
        idle();
        src(4, 1, 4, 0);
        expectOut("unused", 1, 0, 0);
        src(0, 0, 0, 0);
        tick(); tick(); tick();

        // freeze holds state and ignores flush/issue; flush inserts a bubble
        issue(6, 0);
        tick();
        bus.iFreeze = 1'b1;
        bus.iFlush  = 1'b1;
        issue(12, 0);
        src(6, 1, 12, 1);
        for (int i = 0; i < 3; i++) begin
            expectOut("freeze", 1, 0, 0);
            tick();
        end
        expectOut("freeze_end", 1, 0, 0);
        bus.iFreeze = 1'b0;
        issue(8, 0);
        tick();
        idle();
        src(8, 1, 6, 1);
        expectOut("flush", 0, 2, 0);
        src(0, 0, 0, 0);
        tick(); tick(); tick();

        // asynchronous reset between edges
        issue(14, 0);
        tick();
        issue(13, 1);
        tick();
        idle();
        src(14, 1, 13, 1);
        expectOut("pre_rst", 2, 0, 1);
        #1 rst_n = 1'b0;
        expectOut("rst_async", 0, 0, 0);
        tick();
        expectOut("rst_hold", 0, 0, 0);
        #1 rst_n = 1'b1;
        tick();
        expectOut("rst_after", 0, 0, 0);
        issue(13, 0);
        tick();
        idle();
        expectOut("post_rst", 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
